// File: rtl/eth_pipe_pkg.sv
// Shared definitions for the 10-bit AHIR Ethernet pipe (TX and RX sides).
// Word layout: bit 9 = last, bits 8:1 = byte, bit 0 = 0.
package eth_pipe_pkg;

    localparam int PIPE_W   = 10;
    localparam int LAST_BIT = 9;
    localparam int DATA_HI  = 8;
    localparam int DATA_LO  = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        DISCARD = 2'd2
    } pipe_state_t;

    // Builds a canonical pipe word; bit 0 is always driven low.
    function automatic logic [PIPE_W-1:0] pipe_word(input logic last,
                                                    input logic [DATA_HI-DATA_LO:0] byte_v);
        return {last, byte_v, 1'b0};
    endfunction

endpackage

// File: rtl/eth_pipe_out_reg.sv
// One-entry registered AHIR stage: holds a word and its out_req flag until
// the consumer acks it. The parent only loads when the entry is free or draining.
module eth_pipe_out_reg
    import eth_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [PIPE_W-1:0] load_data,
    input  logic              out_ack,
    output logic [PIPE_W-1:0] out_data,
    output logic              out_req
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            out_req  <= 1'b0;
        end else if (load) begin
            out_data <= load_data;
            out_req  <= 1'b1;
        end else if (out_ack) begin
            out_req  <= 1'b0;
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing the TX pipe between two producers.
// Oversized frames are cut at MAX_LEN words (last bit forced) and the rest dropped.
module eth_tx_frame_arbiter
    import eth_pipe_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PIPE_W-1:0] in0_data,
    input  logic              in0_req,
    output logic              in0_ack,
    input  logic [PIPE_W-1:0] in1_data,
    input  logic              in1_req,
    output logic              in1_ack,
    output logic [PIPE_W-1:0] out_data,
    output logic              out_req,
    input  logic              out_ack,
    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  frames0,
    output logic [CNT_W-1:0]  frames1,
    output logic [CNT_W-1:0]  trunc_cnt,
    output pipe_state_t       state_dbg
);

    // Handshake: a word moves on any edge where req & ack are both high; req may
    // drop at any time, ack never depends on req, and out_req depends only on flops.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_state_t       state, state_n;
    logic [1:0]        grant_q, grant_n;
    logic              last_grant, last_grant_n;
    logic [CNT_W-1:0]  word_cnt, word_cnt_n;
    logic [CNT_W-1:0]  frames0_n, frames1_n, trunc_n;
    logic              g_idx, sel_req, sel_last, at_limit, pick;
    logic [DATA_HI-DATA_LO:0] sel_byte;
    logic              ack_g, load, out_req_i;
    logic [PIPE_W-1:0] load_data;
    logic              unused_bit0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    assign unused_bit0 = in0_data[0] ^ in1_data[0];

    assign g_idx    = grant_q[1];
    assign sel_req  = g_idx ? in1_req : in0_req;
    assign sel_last = g_idx ? in1_data[LAST_BIT] : in0_data[LAST_BIT];
    assign sel_byte = g_idx ? in1_data[DATA_HI:DATA_LO] : in0_data[DATA_HI:DATA_LO];
    assign at_limit = (word_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= 2'b00;
            last_grant <= 1'b1;
            word_cnt   <= '0;
            frames0    <= '0;
            frames1    <= '0;
            trunc_cnt  <= '0;
        end else begin
            state      <= state_n;
            grant_q    <= grant_n;
            last_grant <= last_grant_n;
            word_cnt   <= word_cnt_n;
            frames0    <= frames0_n;
            frames1    <= frames1_n;
            trunc_cnt  <= trunc_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant_q;
        last_grant_n = last_grant;
        word_cnt_n   = word_cnt;
        frames0_n    = frames0;
        frames1_n    = frames1;
        trunc_n      = trunc_cnt;
        pick         = 1'b0;
        ack_g        = 1'b0;
        load         = 1'b0;
        load_data    = pipe_word(sel_last | at_limit, sel_byte);
        case (state)
            IDLE: begin
                word_cnt_n = '0;
                if (in0_req | in1_req) begin
                    pick    = (in0_req & in1_req) ? ~last_grant : in1_req;
                    grant_n = pick ? 2'b10 : 2'b01;
                    state_n = XFER;
                end
            end
            XFER: begin
                ack_g = ~out_req_i | out_ack;
                if (sel_req & ack_g) begin
                    load       = 1'b1;
                    word_cnt_n = word_cnt + ONE;
                    if (sel_last | at_limit) begin
                        if (g_idx) frames1_n = sat_inc(frames1);
                        else       frames0_n = sat_inc(frames0);
                    end
                    if (sel_last) begin
                        last_grant_n = g_idx;
                        grant_n      = 2'b00;
                        state_n      = IDLE;
                    end else if (at_limit) begin
                        trunc_n = sat_inc(trunc_cnt);
                        state_n = DISCARD;
                    end
                end
            end
            DISCARD: begin
                // The rest of an oversized frame is swallowed without touching the output.
                ack_g = 1'b1;
                if (sel_req & sel_last) begin
                    last_grant_n = g_idx;
                    grant_n      = 2'b00;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    eth_pipe_out_reg u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .out_ack   (out_ack),
        .out_data  (out_data),
        .out_req   (out_req_i)
    );

    assign out_req   = out_req_i;
    assign in0_ack   = ack_g & grant_q[0];
    assign in1_ack   = ack_g & grant_q[1];
    assign grant     = grant_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter: dut_a uses default sizes, dut_b uses MAX_LEN=16
// and 4-bit counters for truncation and saturation; bsel routes stimulus to one.
module tb_eth_tx_frame_arbiter;
    import eth_pipe_pkg::*;

    localparam int A_MAX = 1518;
    localparam int B_MAX = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bsel = 1'b0;
    logic       bp_mode = 1'b0, bp_check = 1'b0, gap_check = 1'b0;
    logic       ack_tog = 1'b1;
    logic       out_ack;
    logic [9:0] p0_data = '0, p1_data = '0;
    logic       p0_req = 1'b0, p1_req = 1'b0;

    logic [9:0]  a_out_data, b_out_data;
    logic        a_out_req, b_out_req, a_in0_ack, a_in1_ack, b_in0_ack, b_in1_ack;
    logic [1:0]  a_grant, b_grant;
    logic [15:0] a_frames0, a_frames1, a_trunc;
    logic [3:0]  b_frames0, b_frames1, b_trunc;
    pipe_state_t a_state, b_state;

    logic [9:0] out_data_m;
    logic       out_req_m, in0_ack_m, in1_ack_m;
    logic [1:0] grant_m;

    int checks = 0;
    int fails  = 0;
    int cycle  = 0;
    logic [9:0] exp_q[$];

    typedef struct {
        int src;
        int len;
        bit bp;
        bit b0;
        int exp_f0;
        int exp_f1;
    } vec_t;
    vec_t vecs[5];

    always #4 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign out_ack    = bp_mode ? ack_tog : 1'b1;
    assign out_data_m = bsel ? b_out_data : a_out_data;
    assign out_req_m  = bsel ? b_out_req  : a_out_req;
    assign in0_ack_m  = bsel ? b_in0_ack  : a_in0_ack;
    assign in1_ack_m  = bsel ? b_in1_ack  : a_in1_ack;
    assign grant_m    = bsel ? b_grant    : a_grant;

    eth_tx_frame_arbiter #(.MAX_LEN(A_MAX), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .in0_data(p0_data), .in0_req(p0_req & ~bsel), .in0_ack(a_in0_ack),
        .in1_data(p1_data), .in1_req(p1_req & ~bsel), .in1_ack(a_in1_ack),
        .out_data(a_out_data), .out_req(a_out_req), .out_ack(out_ack),
        .grant(a_grant), .frames0(a_frames0), .frames1(a_frames1),
        .trunc_cnt(a_trunc), .state_dbg(a_state)
    );

    eth_tx_frame_arbiter #(.MAX_LEN(B_MAX), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .in0_data(p0_data), .in0_req(p0_req & bsel), .in0_ack(b_in0_ack),
        .in1_data(p1_data), .in1_req(p1_req & bsel), .in1_ack(b_in1_ack),
        .out_data(b_out_data), .out_req(b_out_req), .out_ack(out_ack),
        .grant(b_grant), .frames0(b_frames0), .frames1(b_frames1),
        .trunc_cnt(b_trunc), .state_dbg(b_state)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cycle);
        end
    endtask

    function automatic logic [9:0] mk_word(input int src, input int fid, input int idx,
                                           input int len, input bit b0);
        logic [9:0] w;
        w[9]   = (idx == len - 1);
        w[8]   = src[0];
        w[7]   = fid[0];
        w[6:1] = idx[5:0];
        w[0]   = b0;
        return w;
    endfunction

    task automatic push_exp(input int src, input int len, input int fid, input int maxlen);
        int n;
        logic [9:0] w;
        n = (len < maxlen) ? len : maxlen;
        for (int i = 0; i < n; i++) begin
            w = mk_word(src, fid, i, len, 1'b0);
            if (i == n - 1) w[9] = 1'b1;
            exp_q.push_back(w);
        end
    endtask

    // Sends the first n_send words of a len-word frame; returns at posedge+1.
    task automatic send_frame(input int src, input int len, input int fid, input bit b0,
                              input int n_send);
        logic [9:0] w;
        bit got;
        int n;
        for (int i = 0; i < n_send; i++) begin
            w = mk_word(src, fid, i, len, b0);
            if (src == 0) begin p0_data = w; p0_req = 1'b1; end
            else          begin p1_data = w; p1_req = 1'b1; end
            got = 1'b0;
            n = 0;
            while (!got && n < 2000) begin
                @(negedge clk);
                if ((src == 0) ? in0_ack_m : in1_ack_m) got = 1'b1;
                else n++;
            end
            if (!got) begin
                check("ack_timeout", 0, 1);
                i = n_send;
            end else begin
                check("grant_owner", grant_m, (src == 0) ? 2 'b01 : 2'b10);
                @(posedge clk);
                #1;
            end
        end
        if (src == 0) p0_req = 1'b0;
        else          p1_req = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_req_m) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
        check("idle_grant", grant_m, 2'b00);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic end_segment();
        gap_check = 1'b0;
        bp_check  = 1'b0;
        bp_mode   = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Output scoreboard, word spacing and backpressure ack checks.
    logic [9:0] mon_w;
    int         prev_cycle = 0;
    logic       prev_last = 1'b0;
    logic       have_prev = 1'b0;
    always @(negedge clk) begin
        if (!gap_check) have_prev = 1'b0;
        if (!reset && out_req_m && out_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", out_data_m, 0);
            end else begin
                mon_w = exp_q.pop_front();
                check("out_word", out_data_m, mon_w);
            end
            if (gap_check && have_prev)
                check("word_spacing", cycle - prev_cycle, prev_last ? 2 : 1);
            prev_cycle = cycle;
            prev_last  = out_data_m[9];
            have_prev  = gap_check;
        end
        if (!reset && bp_check && out_req_m && !out_ack)
            check("ack_under_backpressure", in0_ack_m | in1_ack_m, 0);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ack_tog = bp_mode ? ~ack_tog : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{src: 0, len: 64, bp: 1'b0, b0: 1'b0, exp_f0: 1, exp_f1: 0};
        vecs[1] = '{src: 1, len: 1,  bp: 1'b0, b0: 1'b0, exp_f0: 1, exp_f1: 1};
        vecs[2] = '{src: 0, len: 12, bp: 1'b1, b0: 1'b0, exp_f0: 2, exp_f1: 1};
        vecs[3] = '{src: 1, len: 7,  bp: 1'b0, b0: 1'b1, exp_f0: 2, exp_f1: 2};
        vecs[4] = '{src: 1, len: 20, bp: 1'b1, b0: 1'b0, exp_f0: 2, exp_f1: 3};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_req", a_out_req, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_grant", a_grant, 0);
        check("rst_acks", {a_in0_ack, a_in1_ack}, 0);
        check("rst_counters", {a_frames0, a_frames1, a_trunc}, 0);
        check("rst_state", a_state, IDLE);
        @(posedge clk);
        #1;

        for (int r = 0; r < 5; r++) begin
            push_exp(vecs[r].src, vecs[r].len, r, A_MAX);
            gap_check = ~vecs[r].bp;
            bp_mode   = vecs[r].bp;
            bp_check  = vecs[r].bp;
            send_frame(vecs[r].src, vecs[r].len, r, vecs[r].b0, vecs[r].len);
            wait_drain();
            check("vec_frames0", a_frames0, vecs[r].exp_f0);
            check("vec_frames1", a_frames1, vecs[r].exp_f1);
            check("vec_trunc", a_trunc, 0);
            end_segment();
        end

        // Contention from reset: in0 wins the first tie, then strict alternation.
        pulse_reset();
        push_exp(0, 10, 0, A_MAX);
        push_exp(1, 10, 0, A_MAX);
        push_exp(0, 10, 1, A_MAX);
        push_exp(1, 10, 1, A_MAX);
        gap_check = 1'b1;
        fork
            begin
                send_frame(0, 10, 0, 1'b0, 10);
                send_frame(0, 10, 1, 1'b0, 10);
            end
            begin
                send_frame(1, 10, 0, 1'b0, 10);
                send_frame(1, 10, 1, 1'b0, 10);
            end
        join
        wait_drain();
        check("cont_frames0", a_frames0, 2);
        check("cont_frames1", a_frames1, 2);
        end_segment();

        // Reset after word 5 of an in0 frame; the fifth word must never surface.
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_word(0, 0, i, 20, 1'b0));
        send_frame(0, 20, 0, 1'b0, 5);
        pulse_reset();
        @(negedge clk);
        check("mid_rst_out_req", a_out_req, 0);
        check("mid_rst_out_data", a_out_data, 0);
        check("mid_rst_grant", a_grant, 0);
        check("mid_rst_acks", {a_in0_ack, a_in1_ack}, 0);
        check("mid_rst_counters", {a_frames0, a_frames1, a_trunc}, 0);
        check("mid_rst_words_seen", exp_q.size(), 0);
        @(posedge clk);
        #1;
        push_exp(1, 3, 1, A_MAX);
        send_frame(1, 3, 1, 1'b0, 3);
        wait_drain();
        check("post_rst_frames1", a_frames1, 1);
        check("post_rst_frames0", a_frames0, 0);
        end_segment();

        // Truncation on the short-frame instance.
        bsel = 1'b1;
        @(posedge clk);
        #1;
        push_exp(1, 40, 0, B_MAX);
        send_frame(1, 40, 0, 1'b0, 40);
        wait_drain();
        check("trunc_cnt", b_trunc, 1);
        check("trunc_frames1", b_frames1, 1);
        check("trunc_frames0", b_frames0, 0);
        push_exp(0, 3, 1, B_MAX);
        send_frame(0, 3, 1, 1'b0, 3);
        wait_drain();
        check("after_trunc_frames0", b_frames0, 1);
        check("after_trunc_trunc", b_trunc, 1);

        // Saturation of the 4-bit frame counter.
        for (int k = 0; k < 14; k++) begin
            push_exp(0, 1, k, B_MAX);
            send_frame(0, 1, k, 1'b0, 1);
        end
        wait_drain();
        check("sat_reach_max", b_frames0, 15);
        for (int k = 0; k < 6; k++) begin
            push_exp(0, 1, k, B_MAX);
            send_frame(0, 1, k, 1'b0, 1);
        end
        wait_drain();
        check("sat_hold_max", b_frames0, 15);
        check("sat_frames1_untouched", b_frames1, 1);
        end_segment();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/eth_tx_frame_arbiter.md
# eth_tx_frame_arbiter

Frame-granular two-way arbiter that shares the single 10-bit TX pipe feeding the MAC's TX queue between two AHIR producers (e.g. a NIC DMA engine and a control-plane packet injector). Grants are held for a whole frame, delimited by the last bit in each word. Grants alternate round-robin when both producers contend. Oversized frames are truncated, and their remainder is discarded. The block sits directly upstream of the TX SynchFifoWithDPRAM, in the 125 MHz domain.

## Interface
Parameters:
- MAX_LEN, 1518 — maximum words per frame, including the last word; 2..65535.
- CNT_W, 16 — width of the frame and truncation counters.

Ports:
- clk  in  1  — 125 MHz MAC-side clock.
- reset  in  1  — synchronous, active-high.
- in0_data  in  10  — producer 0 word: bit 9 = last, bits 8:1 = byte, bit 0 = 0.
- in0_req  in  1  — producer 0 word valid.
- in0_ack  out  1  — producer 0 word accepted; a transfer occurs when req & ack.
- in1_data / in1_req / in1_ack  — same as producer 0, for producer 1.
- out_data  out  10  — registered word to the TX queue's data_in.
- out_req  out  1  — out_data valid; drives the queue's push_req.
- out_ack  in  1  — queue's push_ack; a transfer occurs when out_req & out_ack.
- grant  out  2  — one-hot owner of the pipe; 00 when idle.
- frames0, frames1  out  CNT_W  — frames forwarded per producer, saturating.
- trunc_cnt  out  CNT_W  — frames truncated, saturating.

## Operation
- Reset: all outputs are 0; state = IDLE; last_grant = 1, so producer 0 wins the first tie; word count = 0.
- **IDLE**
  - No ack is asserted.
  - If exactly one req is high, grant that producer.
  - If both are high, grant the producer that is not last_grant.
  - The grant register is loaded and the state moves to XFER on the next cycle.
  - grant reads 00 only in IDLE.
- **XFER**
  - ack[g] = ~out_req | out_ack; the non-granted ack is 0.
  - Each accepted word is loaded into the output register, with bit 0 forced to 0, and the word count increments.
  - Accepted word with bit 9 = 1: frames[g]++, last_grant <= g, go to IDLE.
  - Accepted word with bit 9 = 0 and count == MAX_LEN-1: the word is forwarded with bit 9 forced to 1; frames[g]++ and trunc_cnt++; go to DISCARD.
- **DISCARD**
  - ack[g] = 1 unconditionally; accepted words are dropped and out_req is not set.
  - Accepted word with bit 9 = 1: last_grant <= g, go to IDLE.
- Output register
  - out_req is set on a load.
  - It clears when out_ack fires and no new load occurs in the same cycle.
  - A simultaneous unload and load keeps out_req high with the new data.
- Counters saturate at all ones.
- A req drop mid-frame is legal and simply stalls the grant; there is no timeout.
- Reset mid-frame: the partial frame is lost, downstream never sees its last word, and the pipe returns to IDLE.

## Timing
- In steady XFER with out_ack high, throughput is one word per cycle.
- Input-to-output latency: 1 cycle (registered output, no skid buffer).
- Frame-to-frame gap: the last word is accepted in cycle N, IDLE arbitrates in N+1, and the first word of the next frame is accepted in N+2. This gives one bubble cycle on out_req.
- When out_ack is held low, out_data and out_req remain stable and ack[g] = 0.
- out_req is never combinationally dependent on in*_req.
- ack[g] depends combinationally on out_ack.

## Structure
- Shared package eth_pipe_pkg:
  - PIPE_W = 10, LAST_BIT = 9, DATA_HI = 8, DATA_LO = 1.
  - State enum {IDLE, XFER, DISCARD}.
  - Reused by the RX-side blocks.
- Sub-module eth_pipe_out_reg: the one-entry registered AHIR stage (load, unload, out_req tracking). It is reusable wherever a pipe must be re-registered.
- The top-level block holds the FSM, round-robin pointer, word counter and saturating counters.

## Test plan
- Single producer: in0 sends a 64-word frame (last on word 64) with out_ack = 1 → 64 words out, consecutive, 1-cycle latency; frames0 = 1; grant = 01 during the frame.
- Contention: both producers hold a 10-word frame pending from reset → order is in0, in1, in0, in1; exactly one bubble between frames; neither frame is interleaved.
- Backpressure: out_ack toggles 1010… during a frame → every word appears exactly once, in order, with no duplication; ack[g] = 0 whenever out_req = 1 and out_ack = 0.
- Truncation: MAX_LEN = 16, in1 sends 40 words → 16 words out, the 16th with bit 9 = 1; the remaining 24 are acked and dropped; trunc_cnt = 1, frames1 = 1; the next in0 frame then passes intact.
- Reset mid-frame: reset is asserted for 1 cycle after word 5 of an in0 frame → all outputs are 0 in the following cycle; a new in1 frame is granted first only if in0 is idle; counters read 0.
- Saturation: CNT_W = 4, send 20 one-word frames from in0 → frames0 holds at 15.
